counter_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit counter register among NUM_REQ requesters. Each requester issues a request, an opcode and a load value, and holds them until acknowledged. The block serializes requests through a two-state FSM, applies exactly one operation per grant, and exposes the counter value, a zero flag and a wrap pulse. It sits between software-visible control ports and the shared counter datapath.

---
 rtl/counter_share_arbiter.sv | 137 +++++++++++++
 tb/tb_counter_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter that shares one counter register among NUM_REQ requesters.
// Each grant spends one ARB cycle latching the winner and one EXEC cycle applying its op.
module counter_share_arbiter #(
  parameter int               NUM_REQ   = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       op,
  input  logic [WIDTH*NUM_REQ-1:0]   data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           counter_val,
  output logic                       is_zero,
  output logic                       wrap
);

  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [IDW-1:0]   ID_ONE   = IDW'(1);
  localparam logic [IDW-1:0]   ID_LAST  = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]     SUM_WRAP = (IDW + 1)'(NUM_REQ);

  typedef enum logic {ARB, EXEC} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [1:0]       opHold_q, opHold_d;
  logic [WIDTH-1:0] dataHold_q, dataHold_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic             winFound;
  logic [IDW-1:0]   winIdx;
  logic [IDW:0]     candSum;

  // Search ptr, ptr+1, ... modulo NUM_REQ; the first active request wins.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    candSum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (candSum >= SUM_WRAP) begin
        candSum = candSum - SUM_WRAP;
      end
      if (!winFound && req[candSum[IDW-1:0]]) begin
        winFound = 1'b1;
        winIdx   = candSum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    opHold_d   = opHold_q;
    dataHold_d = dataHold_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    unique case (state_q)
      ARB: begin
        if (winFound) begin
          state_d    = EXEC;
          grant_d    = winIdx;
          opHold_d   = op[{winIdx, 1'b0} +: 2];
          dataHold_d = data[winIdx * WIDTH +: WIDTH];
        end
      end
      EXEC: begin
        state_d = ARB;
        ptr_d   = (grant_q == ID_LAST) ? '0 : grant_q + ID_ONE;
        // Only the arithmetic ops can wrap; LOAD/CLR never raise wrap.
        unique case (opHold_q)
          OP_INC: begin
            count_d = count_q + CNT_ONE;
            wrap_d  = (count_q == '1);
          end
          OP_DEC: begin
            count_d = count_q - CNT_ONE;
            wrap_d  = (count_q == '0);
          end
          OP_LOAD: count_d = dataHold_q;
          OP_CLR:  count_d = RESET_VAL;
          default: count_d = count_q;
        endcase
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      grant_q    <= '0;
      opHold_q   <= '0;
      dataHold_q <= '0;
      count_q    <= RESET_VAL;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      opHold_q   <= opHold_d;
      dataHold_q <= dataHold_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
    end
  end

  // ack is decoded from the state register so a reset in EXEC removes it at once.
  always_comb begin
    ack = '0;
    if (state_q == EXEC) begin
      ack[grant_q] = 1'b1;
    end
  end

  assign busy        = (state_q == EXEC);
  assign grant_id    = grant_q;
  assign counter_val = count_q;
  assign is_zero     = (count_q == '0);
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Self-checking bench for counter_share_arbiter: directed scenarios with literal
// expectations plus randomized requesters, all compared every cycle against a transaction model.
module tb_counter_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MOD = 256;

  localparam int INC  = 0;
  localparam int DEC  = 1;
  localparam int LOAD = 2;
  localparam int CLR  = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] data;
  logic [N-1:0] ack;
  logic [1:0]   grant_id;
  logic         busy;
  logic [W-1:0] counter_val;
  logic         is_zero;
  logic         wrap;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  counter_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .data(data),
    .ack(ack), .grant_id(grant_id), .busy(busy),
    .counter_val(counter_val), .is_zero(is_zero), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transaction-level model: one pending service slot, a pointer and the counter value.
  bit mBusy  = 0;
  int mPtr   = 0;
  int mGrant = 0;
  int mOp    = 0;
  int mData  = 0;
  int mCount = 0;
  int mWrap  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy = 0; mPtr = 0; mGrant = 0; mOp = 0; mData = 0; mCount = 0; mWrap = 0;
    end else if (!mBusy) begin
      bit found;
      found = 0;
      mWrap = 0;
      for (int d = 0; d < N; d++) begin
        int c;
        c = (mPtr + d) % N;
        if (!found && req[c]) begin
          found  = 1;
          mGrant = c;
          mOp    = int'(op[2*c +: 2]);
          mData  = int'(data[W*c +: W]);
        end
      end
      mBusy = found;
    end else begin
      case (mOp)
        INC:  begin mWrap = (mCount == MOD - 1); mCount = (mCount + 1) % MOD; end
        DEC:  begin mWrap = (mCount == 0); mCount = (mCount + MOD - 1) % MOD; end
        LOAD: begin mWrap = 0; mCount = mData; end
        default: begin mWrap = 0; mCount = 0; end
      endcase
      mPtr  = (mGrant + 1) % N;
      mBusy = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait expired at cycle %0d, got 0, expected 1", name, cyc);
  endtask

  // Every cycle the DUT outputs are held against the model.
  always @(negedge clk) begin
    checkOutput("cmp counter_val", counter_val, mCount);
    checkOutput("cmp is_zero", is_zero, (mCount == 0) ? 1 : 0);
    checkOutput("cmp busy", busy, mBusy ? 1 : 0);
    checkOutput("cmp ack", ack, mBusy ? (1 << mGrant) : 0);
    checkOutput("cmp wrap", wrap, mWrap);
    if (mBusy) checkOutput("cmp grant_id", grant_id, mGrant);
  end

  task automatic applyStimulus(input int id, input int opc, input int dat, input bit en);
    req[id]        = en;
    op[2*id +: 2]  = opc[1:0];
    data[W*id +: W] = dat[W-1:0];
  endtask

  task automatic waitAck(input int id);
    bit got;
    int i;
    got = 0;
    i   = 0;
    while (!got && i < 20) begin
      @(negedge clk);
      got = ack[id];
      i++;
    end
    if (!got) timeoutFail("wait ack");
  endtask

  task automatic waitBusy();
    bit got;
    int i;
    got = 0;
    i   = 0;
    while (!got && i < 20) begin
      @(negedge clk);
      got = busy;
      i++;
    end
    if (!got) timeoutFail("wait busy");
  endtask

  task automatic grabAck(output int id);
    bit got;
    int i;
    got = 0;
    i   = 0;
    id  = -1;
    while (!got && i < 20) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (ack[k]) id = k;
      got = (ack != 0);
      i++;
    end
    if (!got) timeoutFail("wait any ack");
  endtask

  // Full handshake: raise, wait for ack, return just after the update edge with req dropped.
  task automatic doOp(input int id, input int opc, input int dat);
    applyStimulus(id, opc, dat, 1);
    waitAck(id);
    @(posedge clk);
    #1;
    applyStimulus(id, opc, dat, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic runRandom(input int cycles);
    logic [N-1:0] lastAck;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      lastAck = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (lastAck[i]) begin
          if ($urandom_range(0, 9) < 7) applyStimulus(i, 0, 0, 0);
          else applyStimulus(i, $urandom_range(0, 3), $urandom_range(0, 255), 1);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0)
            applyStimulus(i, $urandom_range(0, 3), $urandom_range(0, 255), 1);
        end else if ($urandom_range(0, 3) == 0) begin
          applyStimulus(i, $urandom_range(0, 3), $urandom_range(0, 255), 1);
        end
      end
    end
  endtask

  initial begin
    int updCyc;
    int prevCyc;
    int gid;
    int expOrder [6];
    expOrder = '{0, 1, 2, 3, 0, 2};
    prevCyc  = 0;

    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    data  = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset counter_val", counter_val, 0);
    checkOutput("reset is_zero", is_zero, 1);
    checkOutput("reset ack", ack, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset wrap", wrap, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("idle counter_val", counter_val, 0);
    checkOutput("idle busy", busy, 0);

    // Back-to-back INCs from requester 0 holding req across grants.
    @(posedge clk);
    #1;
    applyStimulus(0, INC, 0, 1);
    for (int g = 1; g <= 3; g++) begin
      waitAck(0);
      @(posedge clk);
      #1;
      updCyc = cyc;
      checkOutput("inc chain value", counter_val, g);
      if (g > 1) checkOutput("inc chain spacing", updCyc - prevCyc, 2);
      prevCyc = updCyc;
      if (g == 3) applyStimulus(0, INC, 0, 0);
    end

    doOp(1, LOAD, 8'hFF);
    checkOutput("load ff value", counter_val, 8'hFF);
    checkOutput("load ff wrap", wrap, 0);
    doOp(1, INC, 0);
    checkOutput("inc wrap value", counter_val, 0);
    checkOutput("inc wrap pulse", wrap, 1);
    checkOutput("inc wrap is_zero", is_zero, 1);
    @(posedge clk);
    #1;
    checkOutput("wrap one cycle", wrap, 0);
    doOp(1, DEC, 0);
    checkOutput("dec wrap value", counter_val, 8'hFF);
    checkOutput("dec wrap pulse", wrap, 1);

    pulseReset();
    for (int i = 0; i < N; i++) applyStimulus(i, INC, 0, 1);
    for (int k = 0; k < 6; k++) begin
      grabAck(gid);
      checkOutput("rr order", gid, expOrder[k]);
      @(posedge clk);
      #1;
      if (gid >= 0) applyStimulus(gid, INC, 0, 0);
      if (k == 3) begin
        applyStimulus(0, INC, 0, 1);
        applyStimulus(2, INC, 0, 1);
      end
    end
    checkOutput("rr count", counter_val, 6);

    // Data changed during EXEC must not reach the counter.
    applyStimulus(3, LOAD, 8'h5A, 1);
    waitBusy();
    #1;
    applyStimulus(3, LOAD, 8'h11, 1);
    @(posedge clk);
    #1;
    checkOutput("load latched data", counter_val, 8'h5A);
    applyStimulus(3, LOAD, 8'h11, 0);
    doOp(3, CLR, 0);
    checkOutput("clr value", counter_val, 0);
    checkOutput("clr no wrap", wrap, 0);

    doOp(1, LOAD, 8'h10);
    applyStimulus(2, INC, 0, 1);
    waitBusy();
    #1;
    rst_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("abort ack", ack, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort counter_val", counter_val, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post abort counter_val", counter_val, 0);
    applyStimulus(1, INC, 0, 1);
    applyStimulus(2, INC, 0, 1);
    grabAck(gid);
    checkOutput("post abort first grant", gid, 1);
    @(posedge clk);
    #1;
    applyStimulus(1, INC, 0, 0);
    grabAck(gid);
    checkOutput("post abort second grant", gid, 2);
    @(posedge clk);
    #1;
    applyStimulus(2, INC, 0, 0);
    checkOutput("post abort count", counter_val, 2);

    runRandom(300);
    pulseReset();
    runRandom(300);
    req = '0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("drain busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
